// File: rtl/uint3_add_arbiter.sv
// uint3_add_arbiter: two requesters share one WIDTH-bit adder through a round-robin arbiter into a one-entry result register
module uint3_add_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_id,
  input  logic             out_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state_q, state_d;
  logic             ptr_q, id_q, carry_q;
  logic [WIDTH-1:0] sum_q;
  logic [7:0]       cnt0_q, cnt1_q;
  logic             can_accept, win, accept;
  logic [WIDTH:0]   res;
  assign can_accept = (state_q == EMPTY) || out_ready;
  // ptr only matters when both are valid; otherwise the lone valid requester wins
  assign win        = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign req0_ready = !RESET && can_accept && req0_valid && !win;
  assign req1_ready = !RESET && can_accept && req1_valid && win;
  assign accept     = req0_ready || req1_ready;
  assign res        = win ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
  always_comb begin
    state_d = state_q;
    state_d = accept ? FULL : (state_q == FULL && out_ready) ? EMPTY : state_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        {carry_q, sum_q} <= res;
        id_q             <= win;
        ptr_q            <= !win;
        cnt0_q           <= cnt0_q + {7'd0, !win};
        cnt1_q           <= cnt1_q + {7'd0, win};
      end
    end
  end
  assign out_valid = (state_q == FULL);
  assign out_sum   = sum_q;
  assign out_carry = carry_q;
  assign out_id    = id_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;
endmodule

// File: tb/tb_uint3_add_arbiter.sv
// tb_uint3_add_arbiter: directed and random stimulus checked against a cycle-level behavioural model
module tb_uint3_add_arbiter;
  localparam int W = 3;
  logic         clk = 1'b0;
  logic         rst;
  logic         v0, v1, r0, r1, ordy;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ovalid, ocarry, oid;
  logic [W-1:0] osum;
  logic [7:0]   c0, c1;
  int n_chk = 0;
  int n_pass = 0;
  bit m_full = 0;
  int m_sum = 0, m_carry = 0, m_id = 0, m_ptr = 0, m_c0 = 0, m_c1 = 0;
  always #5 clk = ~clk;
  uint3_add_arbiter #(.WIDTH(W)) dut (
    .CLK(clk), .RESET(rst),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(r0),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(r1),
    .out_valid(ovalid), .out_sum(osum), .out_carry(ocarry), .out_id(oid),
    .out_ready(ordy), .cnt0(c0), .cnt1(c1)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic step(input bit r, input bit iv0, input int ia0, input int ib0,
                      input bit iv1, input int ia1, input int ib1, input bit ior);
    bit can, e0, e1;
    int s;
    @(negedge clk);
    rst = r; v0 = iv0; a0 = W'(ia0); b0 = W'(ib0);
    v1 = iv1; a1 = W'(ia1); b1 = W'(ib1); ordy = ior;
    #1;
    can = !m_full || ior;
    e0 = !r && can && iv0 && !(iv1 && m_ptr == 1);
    e1 = !r && can && iv1 && !(iv0 && m_ptr == 0);
    check("req0_ready", int'(r0), int'(e0));
    check("req1_ready", int'(r1), int'(e1));
    @(posedge clk);
    if (r) begin
      m_full = 0; m_sum = 0; m_carry = 0; m_id = 0; m_ptr = 0; m_c0 = 0; m_c1 = 0;
    end else if (e0 || e1) begin
      s = e1 ? (ia1 % (1 << W)) + (ib1 % (1 << W)) : (ia0 % (1 << W)) + (ib0 % (1 << W));
      m_sum = s % (1 << W);
      m_carry = s / (1 << W);
      m_id = e1 ? 1 : 0;
      m_ptr = e1 ? 0 : 1;
      if (e1) m_c1 = (m_c1 + 1) % 256;
      else m_c0 = (m_c0 + 1) % 256;
      m_full = 1;
    end else if (m_full && ior) m_full = 0;
    #1;
    check("out_valid", int'(ovalid), int'(m_full));
    if (m_full || r) begin
      check("out_sum", int'(osum), m_sum);
      check("out_carry", int'(ocarry), m_carry);
      check("out_id", int'(oid), m_id);
    end
    check("cnt0", int'(c0), m_c0);
    check("cnt1", int'(c1), m_c1);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 1);
    check("reset_sum", int'(osum), 0);
    step(0, 1, 2, 3, 0, 0, 0, 1);
    check("basic_sum5", int'(osum), 5);
    check("basic_cnt0", int'(c0), 1);
    step(0, 0, 0, 0, 1, 7, 6, 1);
    check("wrap_carry", int'(ocarry), 1);
    step(0, 1, 7, 1, 0, 0, 0, 1);
    check("wrap_zero", int'(osum), 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i, 1, 1, i, 2, 1);
      check("alt_id", int'(oid), i % 2);
    end
    check("cont_cnt0", int'(c0), 2);
    check("cont_cnt1", int'(c1), 2);
    for (int i = 0; i < 3; i++) step(0, 1, i, 3, 1, 5, i, 0);
    step(0, 1, 4, 4, 1, 6, 6, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 256; i++) step(0, 1, i, i + 1, 0, 0, 0, 1);
    check("cnt0_wrap", int'(c0), 0);
    check("cnt1_hold", int'(c1), 0);
    step(0, 0, 0, 0, 1, 3, 3, 1);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 2, 2, 0);
    check("rst_valid", int'(ovalid), 0);
    step(0, 1, 1, 2, 1, 3, 4, 1);
    check("post_rst_id", int'(oid), 0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 9) < 7);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uint3_add_arbiter.md
UINT3_ADD_ARBITER -- requirements
Module: uint3_add_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the operand and sum width in bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset:
- CLK  in  1  clock; all state updates on its rising edge.
- RESET  in  1  synchronous reset, active-high.
REQ-003 The block SHALL provide these requester-0 ports:
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_ready  out  1  requester 0 pair accepted this cycle.
REQ-004 The block SHALL provide req1_valid, req1_a, req1_b and req1_ready, identical in direction, width and meaning to REQ-003, for requester 1.
REQ-005 The block SHALL provide these result ports:
- out_valid  out  1  result register holds a result.
- out_sum  out  WIDTH  (a+b) mod 2^WIDTH.
- out_carry  out  1  carry out of the WIDTH-bit add.
- out_id  out  1  requester that produced the result.
- out_ready  in  1  consumer takes the result.
REQ-006 The block SHALL provide grant counters:
- cnt0  out  8  number of requester-0 accepts.
- cnt1  out  8  number of requester-1 accepts.

Function
REQ-007 The block SHALL contain exactly one WIDTH-bit unsigned adder, time-shared between the two requesters.
REQ-008 The result register SHALL have two states:
- EMPTY: out_valid=0.
- FULL: out_valid=1.
REQ-009 can_accept SHALL be (state==EMPTY) or (out_valid and out_ready) in the same cycle.
REQ-010 The arbiter SHALL use a 1-bit priority pointer ptr; the requester at index ptr wins when both are valid.
REQ-011 Grant rules:
- Only one valid: that requester wins.
- Neither valid: no winner.
REQ-012 reqN_ready SHALL be 1 only when requester N is the winner and can_accept=1.
- Both readies SHALL never be 1 in the same cycle.
- reqN_ready is combinational from the valids, ptr, state and out_ready.
REQ-013 An accept SHALL occur on a rising edge where reqN_valid and reqN_ready are both 1. On an accept:
- out_sum, out_carry = {carry, sum} of the winner's a+b, computed at WIDTH+1 bits.
- out_id <= N.
- state <= FULL.
- ptr <= not N.
- cntN <= cntN+1, wrapping 255->0.
REQ-014 Latency SHALL be exactly one cycle: a pair accepted at edge k is visible on the out_* ports after edge k.
REQ-015 Throughput SHALL be one result per cycle while out_ready is held at 1 (drain and accept in the same cycle).
REQ-016 Drain without accept (out_valid and out_ready, no accept) SHALL set state <= EMPTY.
- out_sum, out_carry and out_id keep their old values; they are don't-care while out_valid=0.
REQ-017 While FULL and out_ready=0, these SHALL all hold stable: out_valid, out_sum, out_carry, out_id, ptr, both counters. Both readies SHALL be 0.
REQ-018 ptr SHALL change only on an accept. Idle cycles and single-requester cycles that do not accept leave ptr unchanged.
REQ-019 Fairness: under continuous contention with out_ready=1, grants SHALL strictly alternate 0,1,0,1...
- A valid requester waits at most one accept by the other requester.
REQ-020 Operand changes while reqN_valid=1 and reqN_ready=0 SHALL have no effect on state. The block samples operands only on the accept edge.

Reset
REQ-021 On a rising edge with RESET=1, the block SHALL set:
- state=EMPTY (out_valid=0).
- out_sum=0, out_carry=0, out_id=0.
- ptr=0.
- cnt0=0, cnt1=0.
REQ-022 RESET SHALL take priority over any same-edge accept or drain. A result held when RESET asserts is discarded. Any request pending during reset is not accepted.
REQ-023 While RESET=1, req0_ready and req1_ready SHALL be 0.

Verification
REQ-024 Basic add (WIDTH=3): req0 a=2 b=3, out_ready=1 -> next cycle out_valid=1, out_sum=5, out_carry=0, out_id=0, cnt0=1.
REQ-025 Wrap and carry: req1 a=7 b=6 -> out_sum=5, out_carry=1, out_id=1. Case a=7 b=1 -> out_sum=0, out_carry=1.
REQ-026 Contention: both valid for 4 cycles after reset, out_ready=1 -> out_id sequence 0,1,0,1; cnt0=2, cnt1=2; one result per cycle.
REQ-027 Backpressure: FULL, out_ready=0 for 3 cycles with both valid -> both readies 0; outputs, ptr and counters stable. Then out_ready=1 -> drain and accept in the same cycle.
REQ-028 Counter wrap: 256 requester-0 accepts -> cnt0 returns to 0; cnt1 unchanged.
REQ-029 Reset mid-operation: FULL with out_id=1, RESET=1 on an edge where req0 is valid -> out_valid=0, ptr=0, counters 0, no accept. First accept after reset goes to requester 0 when both are valid.
